// File: rtl/ym2149_bus_master_pkg.sv
// ym_bus_pkg: shared state encoding, bus modes and register numbers for the PSG bus master
package ym_bus_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, AGAP, WDATA, RDATA, EGAP} state_e;
  localparam logic [1:0] MODE_INACTIVE = 2'b00;
  localparam logic [1:0] MODE_READ     = 2'b01;
  localparam logic [1:0] MODE_WRITE    = 2'b10;
  localparam logic [1:0] MODE_ADDR     = 2'b11;
  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_IOA       = 4'd14;
  localparam logic [3:0] R_IOB       = 4'd15;
  function automatic logic [1:0] state_mode(input state_e s);
    return s == ADDR ? MODE_ADDR : s == WDATA ? MODE_WRITE : s == RDATA ? MODE_READ : MODE_INACTIVE;
  endfunction
endpackage

// File: rtl/ym2149_bus_master.sv
// ym2149_bus_master: turns valid/ready requests into YM2149 address/write/read bus phases timed in CE ticks
module ym2149_bus_master
  import ym_bus_pkg::*;
#(
  parameter int PHASE_CYC = 2,
  parameter bit SKIP_ADDR = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WR,
  input  logic [3:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  input  logic [7:0] DI
);
  state_e     state;
  logic [3:0] cnt;
  logic       wr_q;
  logic [3:0] addr_q;
  logic [7:0] data_q;
  logic [3:0] last_addr;
  logic       last_vld;
  logic       phase_end;
  logic       skip;
  assign phase_end = CE && cnt == 4'(PHASE_CYC - 1);
  assign skip = SKIP_ADDR && last_vld && REQ_ADDR == last_addr;
  assign {BDIR, BC} = state_mode(state);
  assign BUSY = state != IDLE;
  assign REQ_READY = !RESET && state == IDLE;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 4'd0;
      data_q    <= 8'd0;
      last_addr <= 4'd0;
      last_vld  <= 1'b0;
      DO        <= 8'd0;
      RSP_DATA  <= 8'd0;
      RSP_VALID <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      if (state == IDLE) begin
        if (REQ_VALID) begin
          wr_q   <= REQ_WR;
          addr_q <= REQ_ADDR;
          data_q <= REQ_DATA;
          cnt    <= 4'd0;
          state  <= !skip ? ADDR : REQ_WR ? WDATA : RDATA;
          DO     <= !skip ? {4'h0, REQ_ADDR} : REQ_WR ? REQ_DATA : DO;
        end
      end else if (CE) begin
        cnt <= phase_end ? 4'd0 : cnt + 4'd1;
        if (phase_end) begin
          case (state)
            ADDR: begin
              state     <= AGAP;
              last_addr <= addr_q;
              last_vld  <= 1'b1;
            end
            AGAP: begin
              state <= wr_q ? WDATA : RDATA;
              DO    <= wr_q ? data_q : DO;
            end
            WDATA: state <= EGAP;
            RDATA: begin
              state     <= EGAP;
              RSP_DATA  <= DI;
              RSP_VALID <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_ym2149_bus_master.sv
// tb_ym2149_bus_master: directed checks of the PSG bus master against a small behavioural PSG register file
module tb_ym2149_bus_master;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CE;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_WR = 1'b0;
  logic [3:0] REQ_ADDR = 4'd0;
  logic [7:0] REQ_DATA = 8'd0;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BUSY;
  logic       BDIR;
  logic       BC;
  logic [7:0] DO;
  logic [7:0] DI;
  int checks = 0;
  int fails = 0;
  ym2149_bus_master #(.PHASE_CYC(2), .SKIP_ADDR(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY),
    .BDIR(BDIR), .BC(BC), .DO(DO), .DI(DI)
  );
  always #5 CLK = ~CLK;
  logic       ce4 = 1'b0;
  logic [1:0] cdiv = 2'd0;
  assign CE = ce4 ? (cdiv == 2'd0) : 1'b1;
  always @(posedge CLK) cdiv <= cdiv + 2'd1;
  // PSG stand-in: latches address in mode 11, writes in mode 10, port A reads IOA_in when R7[6]=0
  logic [7:0] ymreg [16] = '{default: 8'h00};
  logic [3:0] lat = 4'd0;
  logic [7:0] ioa_in = 8'hA5;
  always @(posedge CLK) begin
    if ({BDIR, BC} == 2'b11) lat <= DO[3:0];
    if ({BDIR, BC} == 2'b10) ymreg[lat] <= DO;
  end
  assign DI = (lat == 4'd14 && !ymreg[7][6]) ? ioa_in : ymreg[lat];
  int   rises = 0, accepts = 0, rsps = 0, ready_bad = 0;
  logic prev_bdir = 1'b0;
  always @(posedge CLK) begin
    if (BDIR && !prev_bdir) rises++;
    prev_bdir = BDIR;
    if (REQ_VALID && REQ_READY) accepts++;
    if (RSP_VALID) rsps++;
    if (REQ_READY && BUSY) ready_bad++;
  end
  logic [1:0] seq [64];
  logic [7:0] dos [64];
  logic       rv  [64];
  logic       rdy [64];
  int         n_seq;
  task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK);
    for (int i = 0; i < 100 && !REQ_READY; i++) @(negedge CLK);
    REQ_WR = wr;
    REQ_ADDR = a;
    REQ_DATA = d;
    REQ_VALID = 1'b1;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask
  task automatic capture();
    n_seq = 0;
    do begin
      @(negedge CLK);
      seq[n_seq] = {BDIR, BC};
      dos[n_seq] = DO;
      rv[n_seq]  = RSP_VALID;
      rdy[n_seq] = REQ_READY;
      n_seq++;
    end while (BUSY && n_seq < 64);
  endtask
  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({REQ_READY, BDIR, BC, BUSY, RSP_VALID, DO, RSP_DATA} !== 21'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {REQ_READY, BDIR, BC, BUSY, RSP_VALID, DO, RSP_DATA});
    end
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b expected 1", REQ_READY);
    end
  endtask
  task automatic test_full_write();
    logic [15:0] got;
    issue(1'b1, 4'd7, 8'h38);
    capture();
    got = '0;
    for (int i = 0; i < 8; i++) got = {got[13:0], seq[i]};
    checks++;
    if (n_seq !== 9) begin fails++; $display("FAIL full_len: got %0d expected 9", n_seq); end
    checks++;
    if (got !== 16'hF0A0) begin fails++; $display("FAIL full_modes: got %h expected f0a0", got); end
    checks++;
    if ({dos[0], dos[1], dos[2], dos[3]} !== 32'h07070707) begin
      fails++;
      $display("FAIL full_do_addr: got %h expected 07070707", {dos[0], dos[1], dos[2], dos[3]});
    end
    checks++;
    if ({dos[4], dos[5], dos[6], dos[7]} !== 32'h38383838) begin
      fails++;
      $display("FAIL full_do_data: got %h expected 38383838", {dos[4], dos[5], dos[6], dos[7]});
    end
    checks++;
    if ({rdy[7], rdy[8]} !== 2'b01) begin fails++; $display("FAIL full_ready: got %b expected 01", {rdy[7], rdy[8]}); end
    checks++;
    if (ymreg[7] !== 8'h38) begin fails++; $display("FAIL full_psg_r7: got %h expected 38", ymreg[7]); end
  endtask
  task automatic test_skip_write();
    logic [7:0] got;
    issue(1'b1, 4'd7, 8'h3F);
    capture();
    got = {seq[0], seq[1], seq[2], seq[3]};
    checks++;
    if (n_seq !== 5) begin fails++; $display("FAIL skip_len: got %0d expected 5", n_seq); end
    checks++;
    if (got !== 8'hA0) begin fails++; $display("FAIL skip_modes: got %h expected a0", got); end
    checks++;
    if (dos[0] !== 8'h3F) begin fails++; $display("FAIL skip_do: got %h expected 3f", dos[0]); end
    checks++;
    if (ymreg[7] !== 8'h3F) begin fails++; $display("FAIL skip_psg_r7: got %h expected 3f", ymreg[7]); end
  endtask
  task automatic test_read();
    logic [15:0] got;
    int          pulses, r0;
    r0 = rsps;
    issue(1'b0, 4'd14, 8'h00);
    capture();
    repeat (3) @(negedge CLK);
    got = '0;
    pulses = 0;
    for (int i = 0; i < 8; i++) got = {got[13:0], seq[i]};
    for (int i = 0; i < n_seq; i++) pulses += int'(rv[i]);
    checks++;
    if (got !== 16'hF050) begin fails++; $display("FAIL read_modes: got %h expected f050", got); end
    checks++;
    if (pulses !== 1 || rv[6] !== 1'b1) begin
      fails++;
      $display("FAIL read_rsp_pulse: got %0d pulses rv6=%b expected 1 at idx 6", pulses, rv[6]);
    end
    checks++;
    if (rsps - r0 !== 1) begin fails++; $display("FAIL read_rsp_count: got %0d expected 1", rsps - r0); end
    checks++;
    if (RSP_DATA !== 8'hA5) begin fails++; $display("FAIL read_data: got %h expected a5", RSP_DATA); end
  endtask
  task automatic test_slow_ce();
    int r0, n00, n10, n11;
    r0 = rises;
    ce4 = 1'b1;
    issue(1'b1, 4'd0, 8'h55);
    capture();
    ce4 = 1'b0;
    n00 = 0; n10 = 0; n11 = 0;
    for (int i = 0; i < n_seq; i++) begin
      if (seq[i] == 2'b11) n11++;
      else if (seq[i] == 2'b10) n10++;
      else if (n11 > 0 && n10 == 0) n00++;
    end
    checks++;
    if (n00 !== 8) begin fails++; $display("FAIL slow_agap_len: got %0d expected 8", n00); end
    checks++;
    if (n10 !== 8) begin fails++; $display("FAIL slow_wdata_len: got %0d expected 8", n10); end
    checks++;
    if (rises - r0 !== 2) begin fails++; $display("FAIL slow_rises: got %0d expected 2", rises - r0); end
    checks++;
    if (ymreg[0] !== 8'h55) begin fails++; $display("FAIL slow_psg_r0: got %h expected 55", ymreg[0]); end
  endtask
  task automatic test_reset_abort();
    int r0;
    issue(1'b1, 4'd7, 8'h11);
    capture();
    issue(1'b1, 4'd7, 8'h22);
    for (int i = 0; i < 20 && {BDIR, BC} != 2'b10; i++) @(negedge CLK);
    checks++;
    if ({BDIR, BC} !== 2'b10) begin fails++; $display("FAIL abort_in_wdata: got %b expected 10", {BDIR, BC}); end
    r0 = rsps;
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BDIR, BC, BUSY, REQ_READY} !== 4'b0001) begin
      fails++;
      $display("FAIL abort_bus_idle: got %b expected 0001", {BDIR, BC, BUSY, REQ_READY});
    end
    issue(1'b1, 4'd7, 8'h33);
    capture();
    checks++;
    if (rsps !== r0) begin fails++; $display("FAIL abort_no_rsp: got %0d expected %0d", rsps, r0); end
    checks++;
    if (seq[0] !== 2'b11 || n_seq !== 9) begin
      fails++;
      $display("FAIL abort_addr_reissued: got mode %b len %0d expected 11 len 9", seq[0], n_seq);
    end
    checks++;
    if (ymreg[7] !== 8'h33) begin fails++; $display("FAIL abort_psg_r7: got %h expected 33", ymreg[7]); end
  endtask
  task automatic test_back_to_back();
    int a0, r0;
    logic [3:0] addrs [3] = '{4'd8, 4'd9, 4'd10};
    logic [7:0] datas [3] = '{8'h0F, 8'h1F, 8'h10};
    a0 = accepts;
    r0 = rises;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_WR = 1'b1;
    for (int k = 0; k < 3; k++) begin
      REQ_ADDR = addrs[k];
      REQ_DATA = datas[k];
      for (int i = 0; i < 100 && !REQ_READY; i++) @(negedge CLK);
      @(posedge CLK);
      #1;
    end
    REQ_VALID = 1'b0;
    for (int i = 0; i < 100 && BUSY; i++) @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (accepts - a0 !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", accepts - a0); end
    checks++;
    if (rises - r0 !== 6) begin fails++; $display("FAIL b2b_rises: got %0d expected 6", rises - r0); end
    checks++;
    if ({ymreg[8], ymreg[9], ymreg[10]} !== 24'h0F1F10) begin
      fails++;
      $display("FAIL b2b_psg_regs: got %h expected 0f1f10", {ymreg[8], ymreg[9], ymreg[10]});
    end
    checks++;
    if (ready_bad !== 0) begin fails++; $display("FAIL ready_while_busy: got %0d expected 0", ready_bad); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_full_write();
    test_skip_write();
    test_read();
    test_slow_ce();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ym2149_bus_master.md
Name: ym2149_bus_master

Overview:
Bus initiator that drives the BDIR/BC/data pins of a ym2149 PSG from a simple valid/ready request interface. It is used by the port decoder and the register-frame player.
- Converts each request into the PSG address / write / read phase sequence, with timing counted in PSG CE ticks.
- Returns read data on a response strobe.
- Optionally skips the address phase when the target register is already latched in the PSG.

Parameters:
PHASE_CYC, 2, CE ticks each bus phase (including gaps) is held; legal range 1..15.
SKIP_ADDR, 1, 1 = omit the address phase when REQ_ADDR equals the last latched address.

Ports:
CLK  in  1  global clock
RESET  in  1  synchronous, active-high reset
CE  in  1  PSG clock enable (same strobe fed to the PSG)
REQ_VALID  in  1  request present
REQ_READY  out  1  request accepted when VALID&READY at a CLK edge
REQ_WR  in  1  1 = write, 0 = read
REQ_ADDR  in  4  PSG register number
REQ_DATA  in  8  write data
RSP_VALID  out  1  one-CLK pulse: RSP_DATA valid
RSP_DATA  out  8  read data
BUSY  out  1  transaction in progress
BDIR  out  1  to PSG BDIR
BC  out  1  to PSG BC
DO  out  8  to PSG DI
DI  in  8  from PSG DO

Behaviour:
- Clocking and reset: one clock (CLK); reset (RESET) is synchronous and active-high.
- Bus modes {BDIR,BC}: 00 inactive, 01 read, 10 write, 11 address.
- Reset values: state IDLE, BDIR=0, BC=0, DO=0, RSP_VALID=0, RSP_DATA=0, BUSY=0, REQ_READY=0 during RESET and 1 afterwards; last-address valid flag cleared.
- States and bus mode per state: IDLE(00), ADDR(11), AGAP(00), WDATA(10), RDATA(01), EGAP(00).
- Every non-IDLE state lasts exactly PHASE_CYC CE ticks. The phase counter resets to 0 on state entry and advances only on CLK edges with CE=1. The state changes on the CLK edge where CE=1 and counter==PHASE_CYC-1. CE=0 freezes everything except RSP_VALID clear.
- IDLE behaviour:
  - REQ_READY=1, BUSY=0.
  - On accept, latch WR, ADDR and DATA; the next state is entered at the next CLK edge, independent of CE.
  - Next state is ADDR, unless SKIP_ADDR=1, the last-address flag is set and REQ_ADDR==last_addr. In that case go straight to WDATA (write) or RDATA (read).
- Transitions:
  - ADDR -> AGAP -> WDATA or RDATA.
  - WDATA -> EGAP.
  - RDATA -> EGAP.
  - EGAP -> IDLE.
- Gaps: the PSG latches on the rising edge of BDIR, so AGAP and EGAP guarantee a rising edge for every address and write phase, including back-to-back requests.
- DO:
  - Equals the latched address from ADDR entry, held through AGAP.
  - Equals the latched data from WDATA entry, held through EGAP.
  - Otherwise holds its last value.
- Last address: on leaving ADDR, last_addr <= latched address and the flag is set.
- Read: DI is sampled on the final CE tick of RDATA. RSP_DATA updates on that edge and RSP_VALID=1 for exactly the following CLK cycle. No response is ever generated for writes.
- Latency in CE ticks, accept to IDLE:
  - Full transaction: 4*PHASE_CYC.
  - Address skipped: 2*PHASE_CYC.
  - IDLE itself costs one CLK cycle between transactions.
- RESET mid-transaction: the bus returns to 00 on the next edge, with no partial response. The last-address flag is cleared, so the next request always issues an address phase.
- REQ_VALID held high while busy: ignored. REQ_READY=0 in all non-IDLE states; no request is lost or duplicated.

Decomposition:
- Package ym_bus_pkg:
  - State enum.
  - Bus-mode constants MODE_INACTIVE=2'b00, MODE_READ=2'b01, MODE_WRITE=2'b10, MODE_ADDR=2'b11.
  - Register index constants (R_MIXER=7, R_IOA=14, R_IOB=15, R_ENV_SHAPE=13).
- Single module; the phase counter is inline, no sub-module.

Test Plan:
Common setup for tests 1-3, 5 and 6: PHASE_CYC=2, CE=1 every cycle, ym2149 instance as responder.
1. After reset, write R7=0x38 -> {BDIR,BC} = 11,11,00,00,10,10,00,00. DO=0x07 during the 11 and first 00 pair, then 0x38. PSG ymreg[7]==0x38. REQ_READY returns after 8 CE ticks.
2. Then write R7=0x3F -> no 11 phase; sequence 10,10,00,00; PSG R7==0x3F; total 4 CE ticks.
3. Set R7[6]=0 and IOA_in=0xA5, then read R14 -> address phase issued (address changed), 01 held 2 ticks. RSP_DATA=0xA5 with a single one-cycle RSP_VALID pulse.
4. CE asserted every 4th CLK, write R0=0x55 -> each phase lasts 8 CLK. PSG R0==0x55. Exactly two BDIR rising edges.
5. RESET asserted during WDATA of a write to R7 -> BDIR=BC=0 next cycle, REQ_READY=1, no RSP_VALID. A following write to R7 includes the 11 phase.
6. REQ_VALID held high for 3 consecutive writes (R8=0x0F, R9=0x1F, R10=0x10) -> exactly 3 accepts and 6 BDIR rising edges. PSG registers match. REQ_READY is never high outside IDLE.
